// File: rtl/soft_rst_req.sv
// Soft-reset request generator: merges software, watchdog and long-press key requests into one pulse with hold-off.
// Define SOFT_RST_WDT_EN to compile in the watchdog path; otherwise wdt_en/wdt_kick are ignored and wdt_warn is 0.
module soft_rst_req #(
    parameter int unsigned DEBOUNCE_CYC   = 1_000_000,
    parameter int unsigned LONG_PRESS_CYC = 150_000_000,
    parameter int unsigned WDT_CYC        = 100_000_000,
    parameter int unsigned WARN_CYC       = 10_000_000,
    parameter int unsigned HOLDOFF_CYC    = 200_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_n,
    input  logic       sw_req,
    input  logic       wdt_en,
    input  logic       wdt_kick,
    output logic       soft_trig_pulse,
    output logic       busy,
    output logic [1:0] cause,
    output logic       wdt_warn
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FIRE    = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    localparam logic [31:0] DB_LAST    = 32'(DEBOUNCE_CYC - 1);
    localparam logic [31:0] PRESS_LAST = 32'(LONG_PRESS_CYC - 1);
    localparam logic [31:0] HOLD_LAST  = 32'(HOLDOFF_CYC - 1);

    state_t      state;
    logic [31:0] hold_cnt;

    logic        key_s1;
    logic        key_s2;
    logic        key_pressed;
    logic        key_db;
    logic [31:0] db_cnt;
    logic [31:0] press_cnt;
    logic        key_used;
    logic        key_req;
    logic        wdt_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            key_s1 <= 1'b1;
            key_s2 <= 1'b1;
        end else begin
            key_s1 <= key_n;
            key_s2 <= key_s1;
        end
    end

    assign key_pressed = ~key_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            key_db <= 1'b0;
            db_cnt <= '0;
        end else if (key_pressed != key_db) begin
            if (db_cnt == DB_LAST) begin
                key_db <= ~key_db;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 32'd1;
            end
        end else begin
            db_cnt <= '0;
        end
    end

    // key_req is registered; key_used latches until release so a held key fires once.
    always_ff @(posedge clk) begin
        if (rst) begin
            press_cnt <= '0;
            key_used  <= 1'b0;
            key_req   <= 1'b0;
        end else begin
            key_req <= 1'b0;
            if (!key_db) begin
                press_cnt <= '0;
                key_used  <= 1'b0;
            end else if (!key_used) begin
                if (press_cnt == PRESS_LAST) begin
                    key_req  <= 1'b1;
                    key_used <= 1'b1;
                end else begin
                    press_cnt <= press_cnt + 32'd1;
                end
            end
        end
    end

`ifdef SOFT_RST_WDT_EN
    localparam logic [31:0] WDT_LAST  = 32'(WDT_CYC - 1);
    localparam logic [31:0] WARN_FROM = 32'(WDT_CYC - WARN_CYC);

    logic [31:0] wdt_cnt;

    // A kick landing on the timeout cycle counts as timely service.
    assign wdt_req  = wdt_en && !wdt_kick && (state == IDLE) && (wdt_cnt == WDT_LAST);
    assign wdt_warn = wdt_en && (wdt_cnt >= WARN_FROM);

    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_cnt <= '0;
        end else if (!wdt_en || wdt_kick || (state != IDLE) || (wdt_cnt == WDT_LAST)) begin
            wdt_cnt <= '0;
        end else begin
            wdt_cnt <= wdt_cnt + 32'd1;
        end
    end
`else
    logic unused_wdt;

    assign unused_wdt = &{1'b0, wdt_en, wdt_kick, WDT_CYC, WARN_CYC};
    assign wdt_req    = 1'b0;
    assign wdt_warn   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            hold_cnt        <= '0;
            soft_trig_pulse <= 1'b0;
            busy            <= 1'b0;
            cause           <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (sw_req || wdt_req || key_req) begin
                        state           <= FIRE;
                        soft_trig_pulse <= 1'b1;
                        busy            <= 1'b1;
                        if (sw_req) begin
                            cause <= 2'b11;
                        end else if (wdt_req) begin
                            cause <= 2'b10;
                        end else begin
                            cause <= 2'b01;
                        end
                    end
                end
                FIRE: begin
                    soft_trig_pulse <= 1'b0;
                    hold_cnt        <= '0;
                    if (HOLDOFF_CYC == 0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= HOLDOFF;
                    end
                end
                HOLDOFF: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 32'd1;
                    end
                end
                default: begin
                    state           <= IDLE;
                    soft_trig_pulse <= 1'b0;
                    busy            <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/soft_rst_req.md
# soft_rst_req

Soft-reset request generator: the producer of the single-cycle `soft_trig_pulse` that feeds the board reset generator. It merges three sources into one pulse with a fixed priority and a fixed hold-off: a debounced long-press on a user key, an optional watchdog timeout, and a direct software request. It runs on the hard-reset domain, so the soft reset it triggers never clears its own hold-off or cause state.

## Interface
- `DEBOUNCE_CYC`, default 1_000_000; cycles the synchronized key level must hold stable before the debounced level follows.
- `LONG_PRESS_CYC`, default 150_000_000; debounced-press cycles required to raise a key request.
- `WDT_CYC`, default 100_000_000; watchdog timeout in cycles.
- `WARN_CYC`, default 10_000_000; `wdt_warn` is high during the final `WARN_CYC` cycles before timeout.
- `HOLDOFF_CYC`, default 200_000; cycles after the pulse during which all requests are dropped. Must be ≥ the downstream reset window.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset. Driven from the hard button reset only, never from the soft-reset output.
- `key_n`  in  1  raw pushbutton, active low, asynchronous.
- `sw_req`  in  1  one-cycle software reset request.
- `wdt_en`  in  1  watchdog enable, level.
- `wdt_kick`  in  1  one-cycle watchdog service.
- `soft_trig_pulse`  out  1  registered, exactly one cycle wide.
- `busy`  out  1  high from the pulse cycle through the end of hold-off.
- `cause`  out  2  last trigger source: 00 none, 01 key, 10 watchdog, 11 software. Sticky.
- `wdt_warn`  out  1  watchdog near timeout.

## Operation
- **Reset values (`rst`=1):** `soft_trig_pulse`=0, `busy`=0, `cause`=00, `wdt_warn`=0, FSM=IDLE, all counters 0. Key sync flops reset to 1 (released); debounced key resets to 0 (released).
- **Key path:**
  - `key_n` passes through a 2-FF synchronizer.
  - The 32-bit debounce counter increments while the synchronized pressed state differs from `key_db`. It clears on any match.
  - When the counter reaches `DEBOUNCE_CYC-1`, `key_db` toggles and the counter clears.
- **Long press:**
  - `press_cnt` increments while `key_db`=1 and `key_used`=0.
  - When `press_cnt`==`LONG_PRESS_CYC-1`, `key_req` is raised for 1 cycle and `key_used` is set.
  - `key_db`=0 clears both `press_cnt` and `key_used`. The key must be released before it can trigger again.
- **Watchdog:**
  - `wdt_cnt` increments each cycle while `wdt_en`=1 and FSM=IDLE.
  - `wdt_kick`=1 or `wdt_en`=0 clears it. A kick has priority over the increment.
  - When `wdt_cnt`==`WDT_CYC-1`, `wdt_req` is raised and the counter clears.
  - `wdt_warn` = `wdt_en` & (`wdt_cnt` ≥ `WDT_CYC-WARN_CYC`).
- **FSM states:**
  - IDLE: any request moves to FIRE. Priority is `sw_req` > `wdt_req` > `key_req`, and `cause` is loaded with the winner. Simultaneous losers are dropped.
  - FIRE: `soft_trig_pulse`=1 and `busy`=1 for exactly 1 cycle. Then go to HOLDOFF, or straight to IDLE if `HOLDOFF_CYC`=0.
  - HOLDOFF: `busy`=1 for `HOLDOFF_CYC` cycles, using a 32-bit counter compared with `HOLDOFF_CYC-1`, then go to IDLE.
- **Requests outside IDLE:** `sw_req` and `wdt_req` are ignored (`wdt_cnt` is held at 0). `key_req` is consumed but not honoured; `key_used` is still set.
- **Reset mid-operation:** `rst` in FIRE or HOLDOFF returns the FSM to IDLE immediately on the next edge, with outputs at their reset values.

## Timing
- Request sampled in IDLE at edge N → `soft_trig_pulse` high in cycle N+1 → `busy` low starting at cycle N+2+`HOLDOFF_CYC`.
- Key: the pulse rises `DEBOUNCE_CYC`+`LONG_PRESS_CYC`+3 edges after the first edge sampling `key_n`=0, provided the key is held stable.
- Watchdog: with the last kick sampled at edge K and `wdt_en` held high, the pulse rises at edge K+`WDT_CYC`+1.
- A bounce shorter than `DEBOUNCE_CYC` cycles never changes `key_db`.

## Configuration
- `SOFT_RST_WDT_EN` defined: the watchdog path is compiled in as specified.
- Undefined:
  - `wdt_req`, `wdt_cnt` and `wdt_warn` are removed; `wdt_warn` is tied to 0.
  - `wdt_en` and `wdt_kick` stay as ports and are ignored.
  - `cause` can never take the value 10.

## Test plan
All scenarios use `DEBOUNCE_CYC`=4, `LONG_PRESS_CYC`=20, `WDT_CYC`=50, `WARN_CYC`=5, `HOLDOFF_CYC`=10, `SOFT_RST_WDT_EN` defined.
- **Software request:** `sw_req` for 1 cycle at edge 100 → pulse at 101 only; `cause`=11; `busy` high for cycles 101–111, low at 112.
- **Key hold:** `key_n` low from edge 0 and held 60 cycles → exactly one pulse, at edge 27, with `cause`=01. Hold for 200 cycles → still exactly one pulse.
- **Key bounce:** `key_n` toggling every 2 cycles for 100 cycles → no pulse; `key_db` stays 0.
- **Watchdog:**
  - `wdt_en`=1 and kicks every 40 cycles → no pulse.
  - Kicks stop, last kick at edge 500 → `wdt_warn` high from edge 546; pulse at 551; `cause`=10.
- **Simultaneous sources:** `sw_req` and `wdt_req` in the same cycle → one pulse with `cause`=11. A second `sw_req` during hold-off → ignored, no second pulse.
- **Reset mid-operation:** `rst` during HOLDOFF → next cycle `busy`=0, `cause`=00, FSM=IDLE. A new `sw_req` after reset produces a pulse 1 cycle later.
